// File: rtl/divider_seq_signed.sv
// Iterative signed divider (restoring shift-and-subtract), one quotient bit per clock.
// Magnitudes are divided unsigned; signs and the /0 and MIN/-1 cases are applied on entry to DONE.
module divider_seq_signed #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    iter_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             dz_reg;
    logic             ov_reg;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // Negating MIN wraps to 2^(WIDTH-1), which is exactly its unsigned magnitude.
    assign a_abs  = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign b_abs  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    assign rem_sh = {rem_reg, quo_reg[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            iter_reg  <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            dvd_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            dz_reg    <= 1'b0;
            ov_reg    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        quo_reg   <= a_abs;
                        dvs_reg   <= b_abs;
                        dvd_reg   <= dividend;
                        rem_reg   <= '0;
                        iter_reg  <= '0;
                        neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_reg <= dividend[WIDTH-1];
                        dz_reg    <= (divisor == '0);
                        ov_reg    <= (dividend == MINV) && (divisor == '1);
                        in_ready  <= 1'b0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    if (iter_reg == CW'(WIDTH)) begin
                        // Final cycle: all quotient bits are in, apply signs and special cases.
                        if (dz_reg) begin
                            quotient  <= dvd_reg[WIDTH-1] ? MINV : MAXV;
                            remainder <= dvd_reg;
                        end else if (ov_reg) begin
                            quotient  <= MAXV;
                            remainder <= '0;
                        end else begin
                            quotient  <= neg_q_reg ? (~quo_reg + WIDTH'(1)) : quo_reg;
                            remainder <= neg_r_reg ? (~rem_reg + WIDTH'(1)) : rem_reg;
                        end
                        div_zero  <= dz_reg;
                        ovf       <= ov_reg;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem_reg <= trial[WIDTH-1:0];
                            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_reg <= rem_sh[WIDTH-1:0];
                            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                        end
                        iter_reg <= iter_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_signed.sv
// Directed test of divider_seq_signed at WIDTH=16: signs, special cases, backpressure, reset mid-op.
module tb_divider_seq_signed;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] dividend;
    logic signed [15:0] divisor;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        quotient;
    logic [15:0]        remainder;
    logic               div_zero;
    logic               ovf;

    int total = 0;
    int bad   = 0;

    divider_seq_signed #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one division; optionally stalls the consumer for 10 cycles before accepting.
    task automatic run_op(input string tag, input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic signed [15:0] eq, input logic signed [15:0] er,
                          input logic edz, input logic eov, input bit stall);
        int cycles;
        @(negedge clk);
        dividend = a; divisor = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk({tag, ".lat"}, cycles, 32'd17);
        chk({tag, ".q"},   {16'd0, quotient},  {16'd0, eq});
        chk({tag, ".r"},   {16'd0, remainder}, {16'd0, er});
        chk({tag, ".dz"},  {31'd0, div_zero},  {31'd0, edz});
        chk({tag, ".ovf"}, {31'd0, ovf},       {31'd0, eov});
        $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0d ovf=%0d latency=%0d",
                 tag, a, b, $signed(quotient), $signed(remainder), div_zero, ovf, cycles);
        if (stall) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                in_valid = 1'b1; dividend = 16'sd9; divisor = 16'sd2;
                @(posedge clk); #1;
                chk({tag, ".hold_v"},   {31'd0, out_valid}, 32'd1);
                chk({tag, ".hold_rdy"}, {31'd0, in_ready},  32'd0);
                chk({tag, ".hold_q"},   {16'd0, quotient},  {16'd0, eq});
                chk({tag, ".hold_r"},   {16'd0, remainder}, {16'd0, er});
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".rdy_after"}, {31'd0, in_ready},  32'd1);
        chk({tag, ".v_after"},   {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        #23;
        chk("rst.v",   {31'd0, out_valid}, 32'd0);
        chk("rst.q",   {16'd0, quotient},  32'd0);
        chk("rst.r",   {16'd0, remainder}, 32'd0);
        chk("rst.dz",  {31'd0, div_zero},  32'd0);
        chk("rst.ovf", {31'd0, ovf},       32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.rdy", {31'd0, in_ready}, 32'd1);

        run_op("pp",     16'sd100,    16'sd7,   16'sd14,     16'sd2,    1'b0, 1'b0, 1'b0);
        run_op("np",    -16'sd100,    16'sd7,  -16'sd14,    -16'sd2,    1'b0, 1'b0, 1'b0);
        run_op("pn",     16'sd100,   -16'sd7,  -16'sd14,     16'sd2,    1'b0, 1'b0, 1'b0);
        run_op("nn",    -16'sd100,   -16'sd7,   16'sd14,    -16'sd2,    1'b0, 1'b0, 1'b0);
        run_op("small",  16'sd7,      16'sd100, 16'sd0,      16'sd7,    1'b0, 1'b0, 1'b0);
        run_op("minm1", -16'sd32768, -16'sd1,   16'sd32767,  16'sd0,    1'b0, 1'b1, 1'b0);
        run_op("min1",  -16'sd32768,  16'sd1,  -16'sd32768,  16'sd0,    1'b0, 1'b0, 1'b0);
        run_op("min7",  -16'sd32768,  16'sd7,  -16'sd4681,  -16'sd1,    1'b0, 1'b0, 1'b0);
        run_op("pz",     16'sd1234,   16'sd0,   16'sd32767,  16'sd1234, 1'b1, 1'b0, 1'b0);
        run_op("nz",    -16'sd5,      16'sd0,  -16'sd32768, -16'sd5,    1'b1, 1'b0, 1'b1);
        run_op("b2b",    16'sd100,    16'sd7,   16'sd14,     16'sd2,    1'b0, 1'b0, 1'b0);

        // Reset asserted in the middle of a calculation.
        @(negedge clk);
        dividend = 16'sd1000; divisor = 16'sd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst.v",   {31'd0, out_valid}, 32'd0);
        chk("mrst.q",   {16'd0, quotient},  32'd0);
        chk("mrst.r",   {16'd0, remainder}, 32'd0);
        chk("mrst.dz",  {31'd0, div_zero},  32'd0);
        chk("mrst.ovf", {31'd0, ovf},       32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst.rdy", {31'd0, in_ready}, 32'd1);
        $display("reset during CALC: outputs cleared");
        run_op("post", 16'sd30000, 16'sd3, 16'sd10000, 16'sd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
